led_frame_rx: RTL and testbench
===============================

# led_frame_rx

Receiver for the LED serial link driven by our LED transmitter: it recovers 32-bit frames from the `cki`/`sdi` clock-data pair and decodes each LED frame into brightness plus 24-bit colour. The stream is a 32-bit all-zero start frame, then `LED_NUM` LED frames, then a 32-bit all-ones end frame. It sits in the 150 MHz domain and serves as the loopback checker for the LED PHY and as the input stage of cascaded LED boards.

## Interface
- `LED_NUM`, default 4: LED frames expected per packet, must be ≥1.
- `TIMEOUT_CNT`, default 64: `clk` cycles without a `cki` rising edge before a partial packet is abandoned.
- `clk` input 1: 150 MHz system clock.
- `rstn` input 1: asynchronous, active-low reset.
- `cki` input 1: serial link clock, asynchronous to `clk`. High and low phases are each ≥3 `clk`.
- `sdi` input 1: serial data, MSB first. It is stable around `cki` rising edges.
- `led_vld` output 1: one-cycle pulse when a decoded LED frame is presented.
- `led_idx` output 11: index of the presented LED frame, from 0 to LED_NUM-1.
- `led_bright` output 5: frame bits [28:24].
- `led_data` output 24: frame bits [23:0], ordered {B,G,R}, the same layout as the transmitter FIFO word.
- `frame_done` output 1: one-cycle pulse when a valid end frame is received.
- `hdr_err` output 1: one-cycle pulse when an LED frame header is not 3'b111.
- `end_err` output 1: one-cycle pulse when the end frame is not 32'hFFFF_FFFF.
- `tmo_err` output 1: one-cycle pulse when the timeout fires.
- `busy` output 1: high whenever the state is not HUNT.

## Operation
- **Input synchronisation**
  - `cki` and `sdi` each pass through a 2-flop synchroniser, giving `cki_s`/`sdi_s`.
  - `cki_s` feeds a third flop, `cki_d`.
  - A bit event is `cki_s & ~cki_d`. On a bit event, `sdi_s` is the sampled bit.
  - Every action below occurs only on a bit event, except the timeout.
- **State HUNT (reset state)**
  - A 6-bit zero-run counter increments on each 0 bit and clears on each 1 bit.
  - When the counter reaches 32, go to ARMED.
- **State ARMED**
  - Further 0 bits are discarded, so longer start frames are tolerated.
  - The first 1 bit is captured as frame bit 31. Set bit_cnt=1, led_cnt=0, and go to DATA.
- **State DATA**
  - Bits shift into a 32-bit shift register, MSB first.
  - When bit_cnt wraps from 31 to 0 (32 bits captured), check the header:
    - Header [31:29] == 3'b111: pulse `led_vld` and register `led_idx`=led_cnt, `led_bright`, `led_data`. Increment led_cnt. If led_cnt was LED_NUM-1, go to TAIL with bit_cnt=0; otherwise stay in DATA.
    - Header ≠ 3'b111: pulse `hdr_err`, go to HUNT, and clear the zero-run counter. `led_vld` is not asserted.
- **State TAIL**
  - Collect 32 bits.
  - If the word is 32'hFFFF_FFFF, pulse `frame_done`; otherwise pulse `end_err`.
  - Either way, go to HUNT with the zero-run counter cleared.
- **Timeout**
  - In ARMED, DATA and TAIL, a 16-bit idle counter increments every `clk` and clears on each bit event.
  - When it reaches TIMEOUT_CNT-1, pulse `tmo_err` and go to HUNT. Partial data is discarded.
  - In HUNT the idle counter is held at 0.
- **Width rules**
  - bit_cnt is 6 bits.
  - led_cnt is 11 bits, compared against LED_NUM-1.
- **Simultaneous events:** a bit event in the same cycle as the timeout threshold clears the idle counter, and the timeout does not fire.

## Timing
- **Reset values:** all outputs are 0, the state is HUNT, and all counters, synchronisers and the shift register are 0.
- **Mid-operation reset:** `rstn` low at any point returns immediately to these values. Reception restarts at HUNT.
- **Latency:** the cycle that registers a `cki` rising edge into the first sync flop is cycle 0. The bit event is evaluated in cycle 2, and `led_vld`/`frame_done`/`*_err` are high in cycle 3 for exactly one cycle.
- **Data hold:** `led_idx`, `led_bright` and `led_data` hold their values until the next `led_vld`.
- **Output exclusivity:** at most one of `led_vld`, `frame_done`, `hdr_err`, `end_err`, `tmo_err` is high in any cycle.
- **Throughput:** one bit per `cki` period. The minimum `cki` period is 6 `clk`, which supports transmitter DIV_CNT ≥ 3.

## Test plan
- **Nominal packet:** transmitter model, DIV_CNT=5. Send start frame, then LED frames E1_0A0B0C, E2_112233, E3_445566, FF_778899, then FFFF_FFFF.
  - Expect 4 `led_vld` pulses with idx 0..3.
  - Expect brightness 1,2,3,31 and data 0A0B0C, 112233, 445566, 778899.
  - Then one `frame_done` pulse, no errors, and `busy`=0 afterwards.
- **Long start frame:** 48 zero bits, then the nominal LED and end frames → identical outputs to the nominal packet.
- **Bad header:** LED frame 1 is 0x6000_0001 → `led_vld` for idx 0 only, then `hdr_err`, HUNT, and no `frame_done`.
- **Bad end frame:** end frame 0xFFFF_FFFE → 4 `led_vld` pulses, then `end_err` instead of `frame_done`.
- **Timeout:** stop `cki` after 10 bits of LED frame 2 → `tmo_err` TIMEOUT_CNT clk after the last edge, `busy`=0. A following full packet decodes correctly.
- **Reset mid-frame:** assert `rstn` during LED frame 1 → all outputs 0 at once. A packet sent after release decodes normally.

Source files
------------

// File: rtl/led_frame_rx.sv
// LED serial link receiver: recovers start/LED/end frames from the cki/sdi pair
// and presents each LED frame as brightness plus {B,G,R} colour.
module led_frame_rx #(
    parameter int LED_NUM     = 4,
    parameter int TIMEOUT_CNT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cki,
    input  logic        sdi,
    output logic        led_vld,
    output logic [10:0] led_idx,
    output logic [4:0]  led_bright,
    output logic [23:0] led_data,
    output logic        frame_done,
    output logic        hdr_err,
    output logic        end_err,
    output logic        tmo_err,
    output logic        busy
);
    typedef enum logic [1:0] {HUNT, ARMED, DATA, TAIL} state_t;

    localparam logic [10:0] LAST_LED = 11'(LED_NUM - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CNT - 1);

    logic        cki_m, cki_s, cki_d, sdi_m, sdi_s;
    logic        bit_ev;
    logic [31:0] word;
    state_t      state, state_n;
    logic [5:0]  zrun, zrun_n, bit_cnt, bit_cnt_n;
    logic [10:0] led_cnt, led_cnt_n;
    logic [30:0] sr, sr_n;
    logic [15:0] idle, idle_n;
    logic        led_ld, vld_n, done_n, herr_n, eerr_n, terr_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cki_m <= 1'b0;
            cki_s <= 1'b0;
            cki_d <= 1'b0;
            sdi_m <= 1'b0;
            sdi_s <= 1'b0;
        end else begin
            cki_m <= cki;
            cki_s <= cki_m;
            cki_d <= cki_s;
            sdi_m <= sdi;
            sdi_s <= sdi_m;
        end
    end

    assign bit_ev = cki_s & ~cki_d;
    // sr keeps the 31 bits already captured; word is the frame including this bit
    assign word   = {sr, sdi_s};
    assign busy   = (state != HUNT);

    always_comb begin
        state_n   = state;
        zrun_n    = zrun;
        bit_cnt_n = bit_cnt;
        led_cnt_n = led_cnt;
        sr_n      = sr;
        idle_n    = 16'd0;
        led_ld    = 1'b0;
        vld_n     = 1'b0;
        done_n    = 1'b0;
        herr_n    = 1'b0;
        eerr_n    = 1'b0;
        terr_n    = 1'b0;
        if (state != HUNT)
            idle_n = bit_ev ? 16'd0 : idle + 16'd1;
        case (state)
            HUNT: begin
                if (bit_ev) begin
                    if (sdi_s) begin
                        zrun_n = 6'd0;
                    end else begin
                        zrun_n = zrun + 6'd1;
                        if (zrun == 6'd31)
                            state_n = ARMED;
                    end
                end
            end
            ARMED: begin
                if (bit_ev && sdi_s) begin
                    sr_n      = 31'd1;
                    bit_cnt_n = 6'd1;
                    led_cnt_n = 11'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_ev) begin
                    sr_n      = word[30:0];
                    bit_cnt_n = (bit_cnt == 6'd31) ? 6'd0 : bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) begin
                        if (word[31:29] == 3'b111) begin
                            vld_n     = 1'b1;
                            led_ld    = 1'b1;
                            led_cnt_n = led_cnt + 11'd1;
                            if (led_cnt == LAST_LED)
                                state_n = TAIL;
                        end else begin
                            herr_n  = 1'b1;
                            zrun_n  = 6'd0;
                            state_n = HUNT;
                        end
                    end
                end
            end
            default: begin
                if (bit_ev) begin
                    sr_n      = word[30:0];
                    bit_cnt_n = (bit_cnt == 6'd31) ? 6'd0 : bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) begin
                        done_n  = (word == 32'hFFFF_FFFF);
                        eerr_n  = (word != 32'hFFFF_FFFF);
                        zrun_n  = 6'd0;
                        state_n = HUNT;
                    end
                end
            end
        endcase
        // a bit event in the threshold cycle wins over the timeout
        if (state != HUNT && !bit_ev && idle == TMO_LAST) begin
            terr_n  = 1'b1;
            zrun_n  = 6'd0;
            idle_n  = 16'd0;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= HUNT;
            zrun       <= 6'd0;
            bit_cnt    <= 6'd0;
            led_cnt    <= 11'd0;
            sr         <= 31'd0;
            idle       <= 16'd0;
            led_vld    <= 1'b0;
            led_idx    <= 11'd0;
            led_bright <= 5'd0;
            led_data   <= 24'd0;
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
            end_err    <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state      <= state_n;
            zrun       <= zrun_n;
            bit_cnt    <= bit_cnt_n;
            led_cnt    <= led_cnt_n;
            sr         <= sr_n;
            idle       <= idle_n;
            led_vld    <= vld_n;
            frame_done <= done_n;
            hdr_err    <= herr_n;
            end_err    <= eerr_n;
            tmo_err    <= terr_n;
            if (led_ld) begin
                led_idx    <= led_cnt;
                led_bright <= word[28:24];
                led_data   <= word[23:0];
            end
        end
    end
endmodule

// File: tb/tb_led_frame_rx.sv
// Self-checking bench for led_frame_rx: table-driven packets, timeout/reset
// sequences, and a random stream checked against a frame-level reference model.
module tb_led_frame_rx;
    localparam int LED_NUM = 4;
    localparam int TMO     = 64;
    localparam int DIV     = 5;

    logic        clk = 1'b0, rstn = 1'b0, cki = 1'b0, sdi = 1'b0;
    logic        led_vld, frame_done, hdr_err, end_err, tmo_err, busy;
    logic [10:0] led_idx;
    logic [4:0]  led_bright;
    logic [23:0] led_data;

    led_frame_rx #(.LED_NUM(LED_NUM), .TIMEOUT_CNT(TMO)) dut (
        .clk(clk), .rstn(rstn), .cki(cki), .sdi(sdi),
        .led_vld(led_vld), .led_idx(led_idx), .led_bright(led_bright),
        .led_data(led_data), .frame_done(frame_done), .hdr_err(hdr_err),
        .end_err(end_err), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // event kinds: 0 led, 1 done, 2 hdr_err, 3 end_err, 4 tmo_err
    typedef struct {
        int               nz;
        logic [3:0][31:0] w;
        logic [31:0]      endw;
        int               nled;
        int               tail;
    } vec_t;

    int total = 0, bad = 0;
    int cyc = 0, last_rise = 0;
    int vld_cyc = 0, done_cyc = 0, tmo_cyc = 0;
    int excl_viol = 0, hold_viol = 0;
    logic [39:0] held = '0;
    logic [43:0] ev_q[$], exp_q[$];

    function automatic logic [43:0] mk(input int k, input logic [10:0] i,
                                       input logic [4:0] b, input logic [23:0] d);
        return {4'(k), i, b, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        held <= {led_idx, led_bright, led_data};
        if (rstn) begin
            if (led_vld)    begin ev_q.push_back(mk(0, led_idx, led_bright, led_data)); vld_cyc <= cyc; end
            if (frame_done) begin ev_q.push_back(mk(1, 0, 0, 0)); done_cyc <= cyc; end
            if (hdr_err)    ev_q.push_back(mk(2, 0, 0, 0));
            if (end_err)    ev_q.push_back(mk(3, 0, 0, 0));
            if (tmo_err)    begin ev_q.push_back(mk(4, 0, 0, 0)); tmo_cyc <= cyc; end
            if ($countones({led_vld, frame_done, hdr_err, end_err, tmo_err}) > 1)
                excl_viol <= excl_viol + 1;
            if (!led_vld && {led_idx, led_bright, led_data} !== held)
                hold_viol <= hold_viol + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_q(input string nm);
        chk({nm, " count"}, 64'(ev_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s ev%0d", nm, i), 64'(ev_q[i]), 64'(exp_q[i]));
        ev_q.delete();
        exp_q.delete();
    endtask

    // transmitter model: sdi changes while cki is low, DIV clk per phase
    task automatic send_bit(input logic b);
        sdi = b;
        repeat (DIV) @(negedge clk);
        cki = 1'b1;
        last_rise = cyc;
        repeat (DIV) @(negedge clk);
        cki = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit chk_lat);
        int r3;
        repeat (v.nz) send_bit(1'b0);
        for (int i = 0; i < LED_NUM; i++) send_word(v.w[i], 32);
        r3 = last_rise;
        send_word(v.endw, 32);
        repeat (20) @(negedge clk);
        for (int i = 0; i < v.nled; i++)
            exp_q.push_back(mk(0, 11'(i), v.w[i][28:24], v.w[i][23:0]));
        if (v.tail != 0) exp_q.push_back(mk(v.tail, 0, 0, 0));
        if (chk_lat) begin
            chk({nm, " vld latency"}, 64'(vld_cyc - r3), 64'd3);
            chk({nm, " done latency"}, 64'(done_cyc - last_rise), 64'd3);
        end
        check_q(nm);
        chk({nm, " busy after"}, 64'(busy), 64'd0);
    endtask

    // frame-level reference: find 32 zeros, skip zeros, slice 32-bit words
    task automatic model(input bit bq[$]);
        int p, n, run;
        bit stop;
        logic [31:0] w;
        p = 0;
        n = bq.size();
        stop = 0;
        while (p < n && !stop) begin
            run = 0;
            while (p < n && run < 32) begin
                run = bq[p] ? 0 : run + 1;
                p++;
            end
            if (run < 32) break;
            while (p < n && !bq[p]) p++;
            if (p >= n) begin exp_q.push_back(mk(4, 0, 0, 0)); break; end
            for (int k = 0; k <= LED_NUM; k++) begin
                if (p + 32 > n) begin exp_q.push_back(mk(4, 0, 0, 0)); stop = 1; break; end
                for (int j = 0; j < 32; j++) w[31-j] = bq[p+j];
                p += 32;
                if (k == LED_NUM) begin
                    exp_q.push_back(mk((w == 32'hFFFF_FFFF) ? 1 : 3, 0, 0, 0));
                end else if (w[31:29] != 3'b111) begin
                    exp_q.push_back(mk(2, 0, 0, 0));
                    break;
                end else begin
                    exp_q.push_back(mk(0, 11'(k), w[28:24], w[23:0]));
                end
            end
        end
    endtask

    initial begin
        vec_t tv[5];
        vec_t nom;
        bit rq[$];
        logic [31:0] w;
        int nz, r;

        nom.nz = 32; nom.nled = 4; nom.tail = 1; nom.endw = 32'hFFFF_FFFF;
        nom.w = {32'hFF77_8899, 32'hE344_5566, 32'hE211_2233, 32'hE10A_0B0C};
        tv[0] = nom;
        tv[1] = nom; tv[1].nz = 48;
        tv[2] = nom; tv[2].w[1] = 32'h6000_0001; tv[2].nled = 1; tv[2].tail = 2;
        tv[3] = nom; tv[3].endw = 32'hFFFF_FFFE; tv[3].tail = 3;
        tv[4] = nom; tv[4].nz = 33;
        tv[4].w = {32'hFFFF_FFFF, 32'hE000_0000, 32'hF0A5_5A5A, 32'hE0FF_FFFF};

        repeat (4) @(negedge clk);
        chk("reset outputs", 64'({led_vld, led_idx, led_bright, led_data, frame_done,
                                  hdr_err, end_err, tmo_err, busy}), 64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(tv[i], $sformatf("vec%0d", i), i == 0);

        // timeout after 10 bits of LED frame 2, then recovery
        repeat (32) send_bit(1'b0);
        send_word(nom.w[0], 32);
        send_word(nom.w[1], 32);
        send_word(nom.w[2], 10);
        r = last_rise;
        chk("busy mid-frame", 64'(busy), 64'd1);
        repeat (TMO + 20) @(negedge clk);
        exp_q.push_back(mk(0, 0, nom.w[0][28:24], nom.w[0][23:0]));
        exp_q.push_back(mk(0, 1, nom.w[1][28:24], nom.w[1][23:0]));
        exp_q.push_back(mk(4, 0, 0, 0));
        check_q("timeout");
        chk("tmo delay", 64'((tmo_cyc - r) >= TMO && (tmo_cyc - r) <= TMO + 4), 64'd1);
        chk("busy after tmo", 64'(busy), 64'd0);
        run_vec(nom, "after tmo", 1'b0);

        // reset in the middle of LED frame 1
        repeat (32) send_bit(1'b0);
        send_word(nom.w[0], 32);
        send_word(nom.w[1], 10);
        exp_q.push_back(mk(0, 0, nom.w[0][28:24], nom.w[0][23:0]));
        check_q("pre-reset");
        #2 rstn = 1'b0;
        #1 chk("mid reset outputs", 64'({led_vld, led_idx, led_bright, led_data, frame_done,
                                         hdr_err, end_err, tmo_err, busy}), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(nom, "after reset", 1'b0);

        // random continuous stream against the reference model
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        for (int pk = 0; pk < 6; pk++) begin
            nz = 32 + $urandom_range(0, 10);
            repeat (nz) rq.push_back(1'b0);
            for (int k = 0; k <= LED_NUM; k++) begin
                w = $urandom();
                if (k < LED_NUM && $urandom_range(0, 3) != 0) w[31:29] = 3'b111;
                if (k == LED_NUM && $urandom_range(0, 3) != 0) w = 32'hFFFF_FFFF;
                for (int j = 31; j >= 0; j--) rq.push_back(w[j]);
            end
        end
        nz = $urandom_range(0, 40);
        repeat (nz) rq.push_back(1'($urandom_range(0, 1)));
        model(rq);
        foreach (rq[i]) send_bit(rq[i]);
        repeat (TMO + 20) @(negedge clk);
        check_q("random");

        chk("exclusive pulses", 64'(excl_viol), 64'd0);
        chk("data hold", 64'(hold_viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
